// File: rtl/spi_sample_writer_if.sv
// Bus bundle for the SPI sample writer: MCU SPI pins on one side, FIFO write port and status on the other.
interface spi_sample_writer_if #(
   parameter int unsigned SAMPLE_WIDTH   = 16,
   parameter int unsigned DROP_CNT_WIDTH = 8
);
   logic                      spi_sclk;
   logic                      spi_cs_n;
   logic                      spi_mosi;
   logic                      fifo_full;
   logic                      fifo_write_en;
   logic [SAMPLE_WIDTH-1:0]   fifo_wdata;
   logic                      overflow;
   logic [DROP_CNT_WIDTH-1:0] drop_count;
   logic                      frame_error;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, fifo_full,
      output fifo_write_en, fifo_wdata, overflow, drop_count, frame_error
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, fifo_full,
      input  fifo_write_en, fifo_wdata, overflow, drop_count, frame_error
   );
endinterface

// File: rtl/spi_sample_writer.sv
// MCU-facing SPI mode-0 slave: oversamples the SPI pins, assembles 16-bit PCM words
// and writes them into the sample FIFO, dropping and counting words when it is full.
module spi_sample_writer #(
   parameter int unsigned SAMPLE_WIDTH   = 16,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned DROP_CNT_WIDTH = 8
) (
   input  logic               clk_12mhz,
   input  logic               reset,
   spi_sample_writer_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH);
   localparam int unsigned LAST  = SYNC_STAGES - 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [SAMPLE_WIDTH-1:0]   shift_q, shift_d;
   logic [SAMPLE_WIDTH-1:0]   word_q, word_d;
   logic [SAMPLE_WIDTH-1:0]   wdata_q, wdata_d;
   logic                      overflow_q, overflow_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   logic                      frame_err_q, frame_err_d;

   logic [SYNC_STAGES-1:0]    sclk_sync, cs_n_sync, mosi_sync;
   logic                      sclk_rise, cs_rise, cs_n_s, mosi_s;
   logic                      write_c;

   // Equal-depth synchronizers keep sclk, cs_n and mosi cycle-aligned
   always_ff @(posedge clk_12mhz) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_n_sync <= '1;
         mosi_sync <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      end
   end

   assign sclk_rise = sclk_sync[LAST-1] & ~sclk_sync[LAST];
   assign cs_rise   = cs_n_sync[LAST-1] & ~cs_n_sync[LAST];
   // Newest aligned cs_n sample, so a rise seen during WRITE already steers back to IDLE
   assign cs_n_s    = cs_n_sync[LAST-1];
   assign mosi_s    = mosi_sync[LAST];

   always_ff @(posedge clk_12mhz) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         word_q      <= '0;
         wdata_q     <= '0;
         overflow_q  <= 1'b0;
         drop_q      <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         overflow_q  <= overflow_d;
         drop_q      <= drop_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      overflow_d  = overflow_q;
      drop_d      = drop_q;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!cs_n_s) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            // A cs_n rise wins over a coincident sclk rise
            if (cs_rise) begin
               frame_err_d = (bit_cnt_q != '0);
               state_d     = IDLE;
            end else if (sclk_rise) begin
               shift_d   = {shift_q[SAMPLE_WIDTH-2:0], mosi_s};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  word_d  = shift_d;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (bus.fifo_full) begin
               overflow_d = 1'b1;
               if (drop_q != '1) drop_d = drop_q + DROP_CNT_WIDTH'(1);
            end else begin
               wdata_d = word_q;
            end
            bit_cnt_d = '0;
            state_d   = cs_n_s ? IDLE : SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end

   // The strobe must see fifo_full in the same cycle, so it is decoded from state
   assign write_c = (state_q == WRITE) && !bus.fifo_full;

   assign bus.fifo_write_en = write_c;
   assign bus.fifo_wdata    = write_c ? word_q : wdata_q;
   assign bus.overflow      = overflow_q;
   assign bus.drop_count    = drop_q;
   assign bus.frame_error   = frame_err_q;
endmodule

// File: tb/tb_spi_sample_writer.sv
// Directed scoreboard bench for spi_sample_writer: expected words queued at stimulus time,
// popped on each FIFO write strobe; status outputs checked at fixed points.
module tb_spi_sample_writer;
   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   wr_count = 0;
   int   fe_count = 0;
   logic [15:0] exp_q[$];

   spi_sample_writer_if #(.SAMPLE_WIDTH(16), .DROP_CNT_WIDTH(8)) bus ();

   spi_sample_writer #(
      .SAMPLE_WIDTH(16),
      .SYNC_STAGES(2),
      .DROP_CNT_WIDTH(8)
   ) dut (
      .clk_12mhz(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest queued word; never strobe while full
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.fifo_write_en) begin
            wr_count++;
            if (bus.fifo_full) check("strobe_while_full", 32'(1), 32'(0));
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(bus.fifo_wdata), 32'hDEAD_BEEF);
            end else begin
               check("sb_word", 32'(bus.fifo_wdata), 32'(exp_q.pop_front()));
            end
         end
         if (bus.frame_error) fe_count++;
      end
   end

   task automatic cs_low();
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      @(negedge clk);
      bus.spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Shift the first nbits of w MSB first; on a full word check strobe latency on the last rise
   task automatic send_word(input logic [15:0] w, input int nbits, input int half, input bit exp_wr);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.spi_mosi = w[15-i];
         repeat (half) @(negedge clk);
         bus.spi_sclk = 1'b1;
         if (i == 15) begin
            @(negedge clk);
            check("pre_strobe", 32'(bus.fifo_write_en), 32'(0));
            @(negedge clk);
            check("strobe_latency", 32'(bus.fifo_write_en), 32'(exp_wr));
            if (exp_wr) check("strobe_data", 32'(bus.fifo_wdata), 32'(w));
            repeat (half - 2) @(negedge clk);
         end else begin
            repeat (half) @(negedge clk);
         end
         bus.spi_sclk = 1'b0;
      end
   endtask

   // cs_n rises at the current negedge: error pulse must appear exactly two negedges later
   task automatic check_abort_pulse(input string tag, input bit exp_err);
      @(negedge clk);
      check({tag, "_fe_early"}, 32'(bus.frame_error), 32'(0));
      check({tag, "_no_write0"}, 32'(bus.fifo_write_en), 32'(0));
      @(negedge clk);
      check({tag, "_fe_pulse"}, 32'(bus.frame_error), 32'(exp_err));
      check({tag, "_no_write1"}, 32'(bus.fifo_write_en), 32'(0));
      @(negedge clk);
      check({tag, "_fe_cleared"}, 32'(bus.frame_error), 32'(0));
   endtask

   initial begin
      logic [15:0] w;
      int wr_before;

      reset          = 1'b1;
      bus.spi_sclk   = 1'b0;
      bus.spi_cs_n   = 1'b1;
      bus.spi_mosi   = 1'b0;
      bus.fifo_full  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_write_en", 32'(bus.fifo_write_en), 32'(0));
      check("rst_wdata", 32'(bus.fifo_wdata), 32'(0));
      check("rst_overflow", 32'(bus.overflow), 32'(0));
      check("rst_drop_count", 32'(bus.drop_count), 32'(0));
      check("rst_frame_error", 32'(bus.frame_error), 32'(0));
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Single word at ~1 MHz SCLK
      exp_q.push_back(16'hA5C3);
      cs_low();
      send_word(16'hA5C3, 16, 6, 1'b1);
      cs_high();
      check("single_wr_count", 32'(wr_count), 32'(1));
      check("single_no_fe", 32'(fe_count), 32'(0));

      // Back-to-back words under one CS
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'hFFFF);
      cs_low();
      send_word(16'h0001, 16, 6, 1'b1);
      send_word(16'hFFFF, 16, 6, 1'b1);
      cs_high();
      check("b2b_wr_count", 32'(wr_count), 32'(3));
      check("b2b_no_fe", 32'(fe_count), 32'(0));
      check("b2b_last_signed", 32'($signed(bus.fifo_wdata)), 32'(-1));

      // Overflow: first dropped word
      bus.fifo_full = 1'b1;
      cs_low();
      send_word(16'h1234, 16, 6, 1'b0);
      cs_high();
      check("ovf_flag", 32'(bus.overflow), 32'(1));
      check("ovf_drop1", 32'(bus.drop_count), 32'(1));
      check("ovf_wdata_held", 32'(bus.fifo_wdata), 32'(16'hFFFF));
      check("ovf_wr_count", 32'(wr_count), 32'(3));

      // 299 more drops: counter saturates at 255
      cs_low();
      for (int n = 0; n < 299; n++) begin
         w = 16'($urandom);
         send_word(w, 16, 3, 1'b0);
      end
      cs_high();
      check("sat_drop", 32'(bus.drop_count), 32'(255));
      check("sat_overflow", 32'(bus.overflow), 32'(1));
      check("sat_wr_count", 32'(wr_count), 32'(3));
      bus.fifo_full = 1'b0;
      repeat (4) @(negedge clk);
      check("sat_hold", 32'(bus.drop_count), 32'(255));

      // Abort after 7 bits
      cs_low();
      send_word(16'hB6D9, 7, 6, 1'b0);
      @(negedge clk);
      bus.spi_cs_n = 1'b1;
      check_abort_pulse("abort7", 1'b1);
      repeat (6) @(negedge clk);
      check("abort_fe_count", 32'(fe_count), 32'(1));
      check("abort_wr_count", 32'(wr_count), 32'(3));

      // Next frame after abort: most negative sample
      exp_q.push_back(16'h8000);
      cs_low();
      send_word(16'h8000, 16, 6, 1'b1);
      check("neg_full_scale", 32'($signed(bus.fifo_wdata)), 32'(-32768));
      cs_high();
      check("neg_wr_count", 32'(wr_count), 32'(4));

      // CS rise coincident with the sclk rise of bit 15
      w = 16'h3C3C;
      cs_low();
      send_word(w, 15, 6, 1'b0);
      @(negedge clk);
      bus.spi_mosi = w[0];
      repeat (6) @(negedge clk);
      bus.spi_cs_n = 1'b1;
      bus.spi_sclk = 1'b1;
      check_abort_pulse("simul", 1'b1);
      bus.spi_sclk = 1'b0;
      repeat (6) @(negedge clk);
      check("simul_wr_count", 32'(wr_count), 32'(4));
      check("simul_fe_count", 32'(fe_count), 32'(2));

      // Reset after 10 bits
      cs_low();
      send_word(16'hFFFF, 10, 6, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      bus.spi_cs_n = 1'b1;
      @(negedge clk);
      check("mid_rst_write_en", 32'(bus.fifo_write_en), 32'(0));
      check("mid_rst_wdata", 32'(bus.fifo_wdata), 32'(0));
      check("mid_rst_overflow", 32'(bus.overflow), 32'(0));
      check("mid_rst_drop", 32'(bus.drop_count), 32'(0));
      check("mid_rst_fe", 32'(bus.frame_error), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      wr_before = wr_count;
      exp_q.push_back(16'h5A5A);
      cs_low();
      send_word(16'h5A5A, 16, 6, 1'b1);
      cs_high();
      check("fresh_once", 32'(wr_count - wr_before), 32'(1));
      check("fresh_no_fe", 32'(fe_count), 32'(2));
      check("sb_drained", 32'(exp_q.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
